// File: rtl/mux_sel_pipe.sv
// N:1 select mux feeding a registered valid/ready output stage with a one-entry skid register.
// Out-of-range selects produce zero data, raise sel_err and bump a saturating event counter.
module mux_sel_pipe #(
  parameter int unsigned BITS   = 16,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     sel_hold,
  input  logic [NUM_IN*BITS-1:0]   din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [BITS-1:0]          dout,
  output logic                     sel_err,
  output logic [CNT_W-1:0]         err_cnt,
  input  logic                     clr_cnt
);

  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t           state, state_nxt;
  logic [BITS-1:0]  s_data, s_data_nxt, dout_nxt, beat_data;
  logic             s_err, s_err_nxt, sel_err_nxt, beat_err;
  logic [SEL_W-1:0] latched_sel, eff_sel;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic             accept, emit, in_ready_nxt, out_valid_nxt;
  logic             load_m_in, load_m_skid, load_s;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // Resolve the incoming beat; any select with no matching input yields zero data and err.
  always_comb begin
    eff_sel   = sel_hold ? latched_sel : sel;
    beat_data = '0;
    beat_err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (eff_sel == SEL_W'(k)) begin
        beat_data = din[k*BITS +: BITS];
        beat_err  = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= EMPTY;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      dout        <= '0;
      sel_err     <= 1'b0;
      s_data      <= '0;
      s_err       <= 1'b0;
      latched_sel <= '0;
      err_cnt     <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      dout      <= dout_nxt;
      sel_err   <= sel_err_nxt;
      s_data    <= s_data_nxt;
      s_err     <= s_err_nxt;
      err_cnt   <= err_cnt_nxt;
      if (accept) latched_sel <= eff_sel;
    end
  end

  // Next-state and register-load decisions.
  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_m_in = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (accept && emit) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          load_s    = 1'b1;
          state_nxt = FULL;
        end else if (emit) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (emit) begin
          load_m_skid = 1'b1;
          state_nxt   = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Next values of the registered outputs, skid entry and error counter.
  always_comb begin
    dout_nxt      = dout;
    sel_err_nxt   = sel_err;
    s_data_nxt    = s_data;
    s_err_nxt     = s_err;
    err_cnt_nxt   = err_cnt;
    in_ready_nxt  = (state_nxt != FULL);
    out_valid_nxt = (state_nxt != EMPTY);
    if (load_m_in) begin
      dout_nxt    = beat_data;
      sel_err_nxt = beat_err;
    end else if (load_m_skid) begin
      dout_nxt    = s_data;
      sel_err_nxt = s_err;
    end
    if (load_s) begin
      s_data_nxt = beat_data;
      s_err_nxt  = beat_err;
    end
    // Clear wins over a same-cycle erroring accept.
    if (clr_cnt) begin
      err_cnt_nxt = '0;
    end else if (accept && beat_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt_nxt = err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe: driver pushes expected beats, a negedge monitor pops and compares.
module tb_mux_sel_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sel_hold, out_valid, out_ready, sel_err, clr_cnt;
  logic [1:0]  sel;
  logic [47:0] din;
  logic [15:0] dout;
  logic [7:0]  err_cnt;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  mux_sel_pipe #(.BITS(16), .NUM_IN(3), .SEL_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .sel_hold(sel_hold), .din(din), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .sel_err(sel_err), .err_cnt(err_cnt),
    .clr_cnt(clr_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: a beat is emitted on the next rising edge whenever out_valid && out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected: got dout=%0d sel_err=%0b, want no beat", dout, sel_err);
      end else begin
        mon_e = sb.pop_front();
        if (dout !== mon_e.data || sel_err !== mon_e.err) begin
          errors++;
          $display("FAIL beat: got dout=%0d sel_err=%0b, want dout=%0d sel_err=%0b",
                   dout, sel_err, mon_e.data, mon_e.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  function automatic logic [47:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] c);
    return {c, b, a};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record its expected output.
  task automatic send(input logic [1:0] s, input logic h, input logic [47:0] d,
                      input logic [15:0] ed, input logic ee);
    int   n;
    exp_t e;
    in_valid = 1'b1;
    sel      = s;
    sel_hold = h;
    din      = d;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, want 1 within 100 cycles");
      in_valid = 1'b0;
      return;
    end
    e.data = ed;
    e.err  = ee;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; sel = 2'd0; sel_hold = 1'b0; din = '0;
    out_ready = 1'b0; clr_cnt = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_sel_err", 32'(sel_err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single beat, one-cycle latency
    out_ready = 1'b1;
    send(2'd1, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd2, 1'b0);
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_dout", 32'(dout), 32'd2);
    chk("t1_sel_err", 32'(sel_err), 32'd0);

    // 2: back-to-back streaming
    send(2'd0, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd1, 1'b0);
    chk("t2_in_ready_a", 32'(in_ready), 32'd1);
    send(2'd1, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd2, 1'b0);
    chk("t2_in_ready_b", 32'(in_ready), 32'd1);
    send(2'd2, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd3, 1'b0);
    chk("t2_in_ready_c", 32'(in_ready), 32'd1);
    drain();

    // 3: stall fills main and skid; third beat waits, order must be 1,3,2
    out_ready = 1'b0;
    send(2'd0, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd1, 1'b0);
    send(2'd2, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd3, 1'b0);
    chk("t3_in_ready_full", 32'(in_ready), 32'd0);
    chk("t3_dout_held", 32'(dout), 32'd1);
    fork
      send(2'd1, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd2, 1'b0);
      begin
        repeat (3) begin
          @(posedge clk); #1;
          chk("t3_stall_dout", 32'(dout), 32'd1);
          chk("t3_stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("t3_in_ready_back", 32'(in_ready), 32'd1);

    // 4: out-of-range select and counter saturation
    send(2'd3, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd0, 1'b0 | 1'b1);
    chk("t4_dout", 32'(dout), 32'd0);
    chk("t4_sel_err", 32'(sel_err), 32'd1);
    chk("t4_err_cnt1", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 299; i++) send(2'd3, 1'b0, pk(16'd4, 16'd5, 16'd6), 16'd0, 1'b1);
    chk("t4_err_cnt_sat", 32'(err_cnt), 32'd255);
    drain();

    // 5: held select, clear priority, held out-of-range select
    send(2'd2, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd3, 1'b0);
    send(2'd0, 1'b1, pk(16'd7, 16'd8, 16'd9), 16'd9, 1'b0);
    chk("t5_hold_dout", 32'(dout), 32'd9);
    clr_cnt = 1'b1;
    send(2'd3, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd0, 1'b1);
    clr_cnt = 1'b0;
    chk("t5_clr_prio", 32'(err_cnt), 32'd0);
    send(2'd3, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd0, 1'b1);
    send(2'd1, 1'b1, pk(16'd1, 16'd2, 16'd3), 16'd0, 1'b1);
    chk("t5_hold_err_cnt", 32'(err_cnt), 32'd2);
    drain();

    // 6: asynchronous reset while FULL
    out_ready = 1'b0;
    send(2'd0, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd1, 1'b0);
    send(2'd1, 1'b0, pk(16'd1, 16'd2, 16'd3), 16'd2, 1'b0);
    in_valid = 1'b0;
    chk("t6_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    chk("t6_err_cnt", 32'(err_cnt), 32'd0);
    chk("t6_dout", 32'(dout), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'd2, 1'b1, pk(16'd1, 16'd2, 16'd3), 16'd1, 1'b0);
    chk("t6_hold_after_rst", 32'(dout), 32'd1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
